mem_store_unit: RTL
===================

Name: mem_store_unit

Overview:
Store path controller between the execute stage and the data memory bus. It is the parametrised successor of the combinational store formatter.
- Accepts one store request per handshake.
- Decodes funct3 into an access size and positions data on byte lanes.
- Generates byte enables and drives valid/ready bus transactions.
- Supports XLEN 32 or 64, including SD.
- Handles misaligned stores by splitting them into two aligned bus beats (optional feature) or by flagging a fault.

Parameters:
XLEN, 32, datapath and bus width in bits; legal values 32 or 64.
NB, XLEN/8, derived: bytes per bus word; not overridable.
OFS_W, $clog2(NB), derived: width of the byte-offset field.

Ports:
iCLK  in  1  clock, rising edge.
iRST_n  in  1  asynchronous, active-low reset.
iValid  in  1  store request valid.
oReady  out  1  unit can accept a request (state IDLE).
iFunct3  in  3  store funct3: 000 SB, 001 SH, 010 SW, 011 SD.
iAddr  in  XLEN  byte address.
iData  in  XLEN  store data, right-aligned.
oBusValid  out  1  bus write request valid.
iBusReady  in  1  bus accepts current beat.
oBusAddr  out  XLEN  word-aligned bus address (low OFS_W bits zero).
oBusWData  out  XLEN  lane-positioned write data.
oBusByteEnable  out  NB  byte-lane write enables.
oDone  out  1  one-cycle pulse: store completed.
oMisaligned  out  1  one-cycle pulse: store rejected as misaligned.
oIllegal  out  1  one-cycle pulse: funct3 illegal for XLEN.

Behaviour:
- Reset: state IDLE; oReady=1; oBusValid=0; oBusAddr, oBusWData, oBusByteEnable all 0; all pulses 0.
- Reset asserted mid-operation aborts the transaction immediately (async); oBusValid drops without waiting for iBusReady.
- Request acceptance:
  - A request is accepted when iValid && oReady.
  - funct3, address and data are registered on acceptance.
  - Inputs are ignored while not IDLE.
- Size decode: SB=1 byte, SH=2, SW=4, SD=8.
  - SD with XLEN=32, or any funct3 >= 100, is illegal.
  - Illegal requests pulse oIllegal the cycle after acceptance, then return to IDLE with no bus activity.
- Lane formatting: off = addr[OFS_W-1:0].
  - wide data (2*XLEN bits) = zero-extended data << (8*off).
  - wide enable (2*NB bits) = ((1<<size)-1) << off.
  - Beat 0 uses the low halves; beat 1 uses the high halves.
- Crossing: the access crosses a word boundary when off+size > NB. Naturally aligned accesses never cross.
- States:
  - IDLE: on acceptance, go to BEAT0 (legal, non-crossing, or crossing with split enabled), to FAULT (crossing without split), or to ILL (illegal funct3).
  - BEAT0: oBusValid=1, oBusAddr = addr with low bits cleared. On iBusReady: go to BEAT1 if crossing, else to IDLE with oDone pulsed.
  - BEAT1: oBusValid=1, oBusAddr = beat-0 address + NB, wrapping modulo 2^XLEN at the top of the address space. On iBusReady: go to IDLE with oDone pulsed.
  - FAULT: oMisaligned pulses for one cycle, then IDLE.
  - ILL: oIllegal pulses for one cycle, then IDLE.
- Bus rule: oBusValid and all bus outputs stay stable while oBusValid && !iBusReady; no beat is ever withdrawn.
- Completion: oDone is a registered pulse in the cycle after the final beat's handshake. oReady reasserts in that same cycle.
- Throughput: best case is one store per 2 cycles. Latency from acceptance to first oBusValid is 1 cycle.
- Bus outputs are registered. oBusByteEnable is 0 whenever oBusValid=0.

Optional Feature:
MISALIGN_SPLIT_EN.
- Defined: crossing stores are split into two beats as above. Non-crossing misaligned stores (e.g. SH at off=1) complete in one beat.
- Undefined: any store with addr mod size != 0 goes to FAULT. BEAT1 is not synthesised; the state encoding may omit it.

Decomposition:
- Shared package mem_pkg holds:
  - FUNCT3_SB/SH/SW/SD constants;
  - a store-size enum;
  - the store-unit state enum;
  - a size_bytes function.
- Sub-module store_lane_fmt: combinational; inputs size, offset and data; outputs the 2*XLEN wide data and 2*NB wide enable. It is reused by the future load aligner.

Test Plan:
- XLEN=32, SW addr 0x100 data 0xDEADBEEF, iBusReady=1 -> one beat: addr 0x100, BE 1111, wdata 0xDEADBEEF; oDone one cycle later.
- XLEN=32, SB addr 0x103 data 0x000000A5 -> BE 1000, wdata 0xA5000000, single beat.
- XLEN=32, SW addr 0x0FE data 0x11223344, split enabled -> beat0 addr 0x0FC BE 1100 wdata 0x33440000; beat1 addr 0x100 BE 0011 wdata 0x00001122. Same request with split disabled -> oMisaligned pulse, no oBusValid.
- XLEN=64, SD addr 0x8 data 0x0102030405060708 -> BE 0xFF, one beat. XLEN=32 with funct3 011 -> oIllegal pulse, no bus traffic.
- Backpressure: iBusReady held 0 for 5 cycles during BEAT0 -> bus outputs stable, oReady=0, iValid ignored; completes after iBusReady=1.
- iRST_n low while in BEAT1 -> oBusValid=0 asynchronously; after release, oReady=1 and no oDone pulse.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory store path (and the future load aligner).
package mem_pkg;

    // Store funct3 encodings
    localparam logic [2:0] FUNCT3_SB = 3'b000;
    localparam logic [2:0] FUNCT3_SH = 3'b001;
    localparam logic [2:0] FUNCT3_SW = 3'b010;
    localparam logic [2:0] FUNCT3_SD = 3'b011;

    // Access size; the encoding equals funct3[1:0] so a plain cast decodes it
    typedef enum logic [1:0] {
        SizeByte   = 2'd0,
        SizeHalf   = 2'd1,
        SizeWord   = 2'd2,
        SizeDouble = 2'd3
    } store_size_e;

    // Store unit FSM states
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StBeat0 = 3'd1,
        StBeat1 = 3'd2,
        StFault = 3'd3,
        StIll   = 3'd4
    } store_state_e;

    // Number of bytes touched by an access of the given size
    function automatic int unsigned size_bytes(input store_size_e size);
        case (size)
            SizeByte: return 1;
            SizeHalf: return 2;
            SizeWord: return 4;
            default:  return 8;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_fmt.sv
// Byte-lane formatter: places right-aligned data and its byte enables at a byte offset
// inside a double-width window. The low half is the first bus word, the high half the next.
module store_lane_fmt
    import mem_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned NB    = XLEN / 8,
    localparam int unsigned OFS_W = $clog2(NB)
) (
    input  logic [OFS_W-1:0]  size_off,
    input  store_size_e       size,
    input  logic [XLEN-1:0]   data,
    output logic [2*XLEN-1:0] wide_data,
    output logic [2*NB-1:0]   wide_be
);

    logic [2*NB-1:0] mask;
    int unsigned     nbytes;

    // Shift zero-extended data and a size-wide enable mask up by the byte offset
    always_comb begin
        nbytes = size_bytes(size);
        mask   = '0;
        for (int unsigned i = 0; i < 2 * NB; i++) begin
            mask[i] = (i < nbytes);
        end
        wide_data = {{XLEN{1'b0}}, data} << {size_off, 3'b000};
        wide_be   = mask << size_off;
    end

endmodule

// File: rtl/mem_store_unit.sv
// Store path controller: accepts one store per handshake, formats it onto byte lanes and
// issues one or two aligned bus beats.
// Build option MISALIGN_SPLIT_EN: when defined, word-crossing stores are split into two
// beats; when undefined, any store not aligned to its size is rejected as misaligned.
module mem_store_unit
    import mem_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic                iValid,
    output logic                oReady,
    input  logic [2:0]          iFunct3,
    input  logic [XLEN-1:0]     iAddr,
    input  logic [XLEN-1:0]     iData,
    output logic                oBusValid,
    input  logic                iBusReady,
    output logic [XLEN-1:0]     oBusAddr,
    output logic [XLEN-1:0]     oBusWData,
    output logic [XLEN/8-1:0]   oBusByteEnable,
    output logic                oDone,
    output logic                oMisaligned,
    output logic                oIllegal
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFS_W = $clog2(NB);

    store_state_e state_q, state_d;

    logic            bus_valid_q, bus_valid_d;
    logic [XLEN-1:0] bus_addr_q, bus_addr_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
    logic [NB-1:0]   bus_be_q, bus_be_d;
    logic            done_q, done_d;

`ifdef MISALIGN_SPLIT_EN
    // Second-beat payload, captured at acceptance
    logic            cross_q, cross_d;
    logic [XLEN-1:0] hi_wdata_q, hi_wdata_d;
    logic [NB-1:0]   hi_be_q, hi_be_d;
`endif

    // Request decode, straight from the inputs (only consumed while idle)
    logic [OFS_W-1:0]   req_off;
    store_size_e        req_size;
    int unsigned        req_bytes;
    logic               req_illegal;
    logic               req_fault;
    logic [XLEN-1:0]    req_base;
    logic [2*XLEN-1:0]  wide_data;
    logic [2*NB-1:0]    wide_be;

    assign req_off     = iAddr[OFS_W-1:0];
    assign req_size    = store_size_e'(iFunct3[1:0]);
    assign req_bytes   = size_bytes(req_size);
    assign req_illegal = iFunct3[2] || ((iFunct3 == FUNCT3_SD) && (XLEN == 32));
    assign req_base    = {iAddr[XLEN-1:OFS_W], {OFS_W{1'b0}}};

`ifdef MISALIGN_SPLIT_EN
    logic req_cross;
    assign req_cross = (32'(req_off) + req_bytes) > NB;
    assign req_fault = 1'b0;
`else
    // Without splitting, anything not aligned to its own size is refused
    assign req_fault = (req_off & OFS_W'(req_bytes - 1)) != '0;

    // Second-beat halves have no consumer in this build
    logic unused_hi;
    assign unused_hi = ^{wide_data[2*XLEN-1:XLEN], wide_be[2*NB-1:NB]};
`endif

    store_lane_fmt #(
        .XLEN (XLEN)
    ) u_lane_fmt (
        .size_off  (req_off),
        .size      (req_size),
        .data      (iData),
        .wide_data (wide_data),
        .wide_be   (wide_be)
    );

    // Next-state and next bus-register values
    always_comb begin
        state_d     = state_q;
        bus_valid_d = bus_valid_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        done_d      = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        cross_d     = cross_q;
        hi_wdata_d  = hi_wdata_q;
        hi_be_d     = hi_be_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (iValid) begin
                    if (req_illegal) begin
                        state_d = StIll;
                    end else if (req_fault) begin
                        state_d = StFault;
                    end else begin
                        state_d     = StBeat0;
                        bus_valid_d = 1'b1;
                        bus_addr_d  = req_base;
                        bus_wdata_d = wide_data[XLEN-1:0];
                        bus_be_d    = wide_be[NB-1:0];
`ifdef MISALIGN_SPLIT_EN
                        cross_d     = req_cross;
                        hi_wdata_d  = wide_data[2*XLEN-1:XLEN];
                        hi_be_d     = wide_be[2*NB-1:NB];
`endif
                    end
                end
            end

            StBeat0: begin
                if (iBusReady) begin
`ifdef MISALIGN_SPLIT_EN
                    if (cross_q) begin
                        state_d     = StBeat1;
                        bus_addr_d  = bus_addr_q + XLEN'(NB);
                        bus_wdata_d = hi_wdata_q;
                        bus_be_d    = hi_be_q;
                    end else begin
                        state_d     = StIdle;
                        bus_valid_d = 1'b0;
                        bus_addr_d  = '0;
                        bus_wdata_d = '0;
                        bus_be_d    = '0;
                        done_d      = 1'b1;
                    end
`else
                    state_d     = StIdle;
                    bus_valid_d = 1'b0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    bus_be_d    = '0;
                    done_d      = 1'b1;
`endif
                end
            end

`ifdef MISALIGN_SPLIT_EN
            StBeat1: begin
                if (iBusReady) begin
                    state_d     = StIdle;
                    bus_valid_d = 1'b0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    bus_be_d    = '0;
                    done_d      = 1'b1;
                end
            end
`endif

            StFault, StIll: begin
                state_d = StIdle;
            end

            default: begin
                state_d     = StIdle;
                bus_valid_d = 1'b0;
                bus_addr_d  = '0;
                bus_wdata_d = '0;
                bus_be_d    = '0;
            end
        endcase
    end

    // State and registered bus outputs; reset aborts any beat in flight
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= StIdle;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            done_q      <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            cross_q     <= 1'b0;
            hi_wdata_q  <= '0;
            hi_be_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bus_valid_q <= bus_valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            done_q      <= done_d;
`ifdef MISALIGN_SPLIT_EN
            cross_q     <= cross_d;
            hi_wdata_q  <= hi_wdata_d;
            hi_be_q     <= hi_be_d;
`endif
        end
    end

    assign oReady         = (state_q == StIdle);
    assign oBusValid      = bus_valid_q;
    assign oBusAddr       = bus_addr_q;
    assign oBusWData      = bus_wdata_q;
    assign oBusByteEnable = bus_be_q;
    assign oDone          = done_q;
    assign oMisaligned    = (state_q == StFault);
    assign oIllegal       = (state_q == StIll);

endmodule
